// File: rtl/img_gray_loader.sv
// RGB-to-grayscale frame loader: fills the gray-image memory and hands whole frames to the convolution engine.
// Optional start-of-frame resynchronisation is enabled by defining IMG_SOF_RESYNC_EN.
module img_gray_loader #(
    parameter int          IMG_W  = 128,
    parameter int          IMG_H  = 128,
    parameter int          ADDR_W = 14,
    parameter logic [7:0]  KR     = 8'd77,
    parameter logic [7:0]  KG     = 8'd150,
    parameter logic [7:0]  KB     = 8'd29
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       in_rgb,
    input  logic              in_sof,
    output logic              wen_img,
    output logic [ADDR_W-1:0] addr_img,
    output logic [7:0]        w_data_img,
    output logic              conv_ready,
    input  logic              conv_busy,
    output logic [7:0]        frame_cnt,
    output logic              frame_err
);

    localparam int              STAGES = 2;
    localparam int              CW     = ADDR_W + 1;
    localparam logic [CW-1:0]   TOTAL  = CW'(IMG_W * IMG_H);

    typedef enum logic [1:0] {LOAD, HANDOFF, RUN} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic                xfer, take, restart, err_nxt;
    // [0] captured pixel, [1] weighted sum, [2] memory write
    logic [STAGES:0]     vld_pipe;
    logic [23:0]         rgb_q;
    logic [ADDR_W-1:0]   addr_q, addr_s1;
    logic [16:0]         sum_c, sum_s1;
    logic                unused_bits;

    assign wen_img     = vld_pipe[STAGES];
    assign unused_bits = ^{sum_s1[16], in_sof};

    always_comb begin
        sum_c = {9'd0, KR} * {9'd0, rgb_q[23:16]}
              + {9'd0, KG} * {9'd0, rgb_q[15:8]}
              + {9'd0, KB} * {9'd0, rgb_q[7:0]}
              + 17'd128;
    end

    always_comb begin
        xfer    = in_valid && in_ready;
        take    = xfer;
        restart = 1'b0;
`ifdef IMG_SOF_RESYNC_EN
        err_nxt = frame_err;
        // A misplaced SOF restarts the frame; a missing one drops the pixel.
        if (xfer && in_sof && cnt != '0) begin
            restart = 1'b1;
            err_nxt = 1'b1;
        end
        if (xfer && !in_sof && cnt == '0) begin
            take    = 1'b0;
            err_nxt = 1'b1;
        end
`else
        err_nxt = 1'b0;
`endif
        cnt_nxt   = cnt;
        state_nxt = state;
        if (restart)   cnt_nxt = CW'(1);
        else if (take) cnt_nxt = cnt + CW'(1);
        case (state)
            LOAD:    if (cnt == TOTAL && vld_pipe[1:0] == '0) state_nxt = HANDOFF;
            HANDOFF: if (conv_busy) state_nxt = RUN;
            RUN: begin
                if (!conv_busy) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            cnt        <= '0;
            in_ready   <= 1'b0;
            conv_ready <= 1'b0;
            frame_cnt  <= 8'd0;
            frame_err  <= 1'b0;
            vld_pipe   <= '0;
            rgb_q      <= 24'd0;
            addr_q     <= '0;
            sum_s1     <= 17'd0;
            addr_s1    <= '0;
            w_data_img <= 8'd0;
            addr_img   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            in_ready   <= (state_nxt == LOAD) && (cnt_nxt < TOTAL);
            conv_ready <= (state_nxt == HANDOFF);
            frame_err  <= err_nxt;
            if (state == RUN && state_nxt == LOAD) frame_cnt <= frame_cnt + 8'd1;
            vld_pipe   <= {vld_pipe[STAGES-1:0], take};
            if (take) begin
                rgb_q  <= in_rgb;
                addr_q <= restart ? '0 : cnt[ADDR_W-1:0];
            end
            if (vld_pipe[0]) begin
                sum_s1  <= sum_c;
                addr_s1 <= addr_q;
            end
            if (vld_pipe[1]) begin
                w_data_img <= sum_s1[15:8];
                addr_img   <= addr_s1;
            end
        end
    end

endmodule

// File: tb/tb_img_gray_loader.sv
// Randomized bench for img_gray_loader: a queue-based reference model predicts every memory write and
// its exact cycle; frame handoff, reset and boundary behaviour are checked directly.
module tb_img_gray_loader;

    localparam int W = 128, H = 128, TOTAL = W * H, AW = 14;

    logic          clk = 1'b0, reset = 1'b1;
    logic          in_valid = 1'b0, in_sof = 1'b0, conv_busy = 1'b0;
    logic [23:0]   in_rgb = 24'd0;
    logic          in_ready, wen_img, conv_ready, frame_err;
    logic [AW-1:0] addr_img;
    logic [7:0]    w_data_img, frame_cnt;

    int checks = 0, errors = 0, cyc = 0;
    int last_wen_cyc = -1;
    bit chk_en = 1'b0, ld_done = 1'b0;

    typedef struct {int addr; int data; int due;} wr_t;
    wr_t exp_q[$];
    logic [7:0]  cap [4];
    logic [23:0] pin_rgb [4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};

    img_gray_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rgb(in_rgb), .in_sof(in_sof), .wen_img(wen_img), .addr_img(addr_img),
        .w_data_img(w_data_img), .conv_ready(conv_ready), .conv_busy(conv_busy),
        .frame_cnt(frame_cnt), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gray(input logic [23:0] p);
        return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]) + 128) / 256;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the write queue.
    initial begin
        bit exp_w;
        forever begin
            @(negedge clk);
            if (chk_en && !reset) begin
                while (exp_q.size() != 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
                exp_w = (exp_q.size() != 0) && (exp_q[0].due == cyc);
                check("wen_img", int'(wen_img), int'(exp_w));
                if (exp_w) begin
                    check("addr_img", int'(addr_img), exp_q[0].addr);
                    check("w_data_img", int'(w_data_img), exp_q[0].data);
                    if (exp_q[0].addr < 4) cap[exp_q[0].addr] = w_data_img;
                    last_wen_cyc = cyc;
                    void'(exp_q.pop_front());
                end
                if (ld_done) check("in_ready_after_last", int'(in_ready), 0);
                check("frame_err", int'(frame_err), 0);
            end
        end
    end

    task automatic drive_frame(input int gap, input bit gray_pat, input bit pinned, input int stop_at);
        int sent = 0;
        int budget = 0;
        ld_done = 1'b0;
        while (sent < stop_at) begin
            @(negedge clk);
            if (budget++ > 40000) begin
                checks++; errors++;
                $display("FAIL drive_timeout actual=%0d expected=%0d", sent, stop_at);
                break;
            end
            in_valid = ($urandom_range(0, 99) >= gap);
            in_rgb   = 24'($urandom);
            if (gray_pat) in_rgb = {3{sent[7:0]}};
            if (pinned && sent < 4) in_rgb = pin_rgb[sent];
            in_sof   = (sent == 0);
            if (in_valid && in_ready) begin
                exp_q.push_back('{sent, gray(in_rgb), cyc + 3});
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (sent == TOTAL) ld_done = 1'b1;
    endtask

    task automatic handoff(input bit busy_early, input int hold, input int exp_fc);
        int n = 0;
        if (busy_early) conv_busy = 1'b1;
        while (!conv_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("conv_ready_rise", int'(conv_ready), 1);
        check("conv_ready_latency", cyc, last_wen_cyc + 1);
        check("in_ready_handoff", int'(in_ready), 0);
        if (!busy_early) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("conv_ready_hold", int'(conv_ready), 1);
            end
            conv_busy = 1'b1;
        end
        @(negedge clk);
        check("conv_ready_drop", int'(conv_ready), 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (in_ready || conv_ready) check("run_idle", int'({in_ready, conv_ready}), 0);
        end
        check("frame_cnt_run", int'(frame_cnt), (exp_fc + 255) % 256);
        ld_done   = 1'b0;
        conv_busy = 1'b0;
        @(negedge clk);
        check("frame_cnt", int'(frame_cnt), exp_fc % 256);
        check("in_ready_reload", int'(in_ready), 1);
        check("conv_ready_run_end", int'(conv_ready), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 0);
        check({tag, "_wen"}, int'(wen_img), 0);
        check({tag, "_addr"}, int'(addr_img), 0);
        check({tag, "_data"}, int'(w_data_img), 0);
        check({tag, "_conv_ready"}, int'(conv_ready), 0);
        check({tag, "_frame_cnt"}, int'(frame_cnt), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;
        #1 check("in_ready_release", int'(in_ready), 0);
        @(negedge clk);
        check("in_ready_rise", int'(in_ready), 1);
        chk_en = 1'b1;

        // Frame A: back-to-back, four pinned pixels first, engine busy for 1000 cycles.
        drive_frame(0, 1'b0, 1'b1, TOTAL);
        handoff(1'b0, 1000, 1);
        check("pin_red", int'(cap[0]), 77);
        check("pin_green", int'(cap[1]), 149);
        check("pin_blue", int'(cap[2]), 29);
        check("pin_white", int'(cap[3]), 255);

        // Frame B: ~30% input gaps, busy already high when the frame completes.
        drive_frame(30, 1'b0, 1'b0, TOTAL);
        handoff(1'b1, 50, 2);

        // Frame C: reset in the middle, then a full gray-ramp frame from address 0.
        drive_frame(10, 1'b0, 1'b0, 5000);
        reset = 1'b1;
        #1 check_reset_state("midrst");
        exp_q.delete();
        ld_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 check("in_ready_release2", int'(in_ready), 0);
        drive_frame(0, 1'b1, 1'b0, TOTAL);
        handoff(1'b0, 20, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
